arb_req_queue: RTL and testbench

Input stage in front of the 4-way round-robin arbiter. It holds one small FIFO per requester and drives the arbiter's req vector from FIFO occupancy. It consumes the arbiter's registered one-hot gnt to pop the granted FIFO into a single registered output stage with a valid/ready handshake. The output tags each transaction with the index of the source requester.

---
 rtl/arb_req_queue_pkg.sv | 20 ++
 rtl/arb_req_queue_if.sv | 29 ++
 rtl/arb_req_queue_fifo.sv | 48 ++++
 rtl/arb_req_queue.sv | 91 +++++++++
 tb/tb_arb_req_queue.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/arb_req_queue_pkg.sv
// arb_pkg: types shared by the request queue and the round-robin arbiter.
// Provides the requester count, vector/index types and a grant encoder.
package arb_pkg;

  localparam int NREQ = 4;

  typedef logic [1:0]      src_t;
  typedef logic [NREQ-1:0] vec_t;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic src_t low_idx(vec_t v);
    src_t r;
    r = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (v[i]) r = src_t'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/arb_req_queue_if.sv
// arb_req_queue_if: per-requester push side, arbiter req/gnt and the
// single tagged output handshake. slave = queue, master = its environment.
interface arb_req_queue_if
  import arb_pkg::*;
#(
  parameter int DW = 8
);

  vec_t               in_valid;
  logic [NREQ*DW-1:0] in_data;
  vec_t               in_ready;
  vec_t               req;
  vec_t               gnt;
  logic               out_valid;
  logic [DW-1:0]      out_data;
  src_t               out_src;
  logic               out_ready;

  modport slave (
    input  in_valid, in_data, gnt, out_ready,
    output in_ready, req, out_valid, out_data, out_src
  );

  modport master (
    output in_valid, in_data, gnt, out_ready,
    input  in_ready, req, out_valid, out_data, out_src
  );

endinterface

// File: rtl/arb_req_queue_fifo.sv
// req_fifo: small per-requester FIFO with occupancy count.
// Caller guarantees no push when full and no pop when empty.
module req_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [DW-1:0]          din,
  input  logic                   pop,
  output logic [DW-1:0]          dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  assign dout  = mem[rptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Storage write; contents are don't-care until counted valid.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  // Pointers wrap naturally (power-of-two depth); count tracks occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/arb_req_queue.sv
// arb_req_queue: per-requester FIFOs feeding the arbiter, one tagged output.
// Optional ARB_REQ_LOOKAHEAD_EN: req anticipates this cycle's push/pop.
module arb_req_queue
  import arb_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input logic              clk,
  input logic              rst,
  arb_req_queue_if.slave   bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  vec_t          push;
  vec_t          pop;
  vec_t          full;
  vec_t          empty;
  vec_t          req_v;
  logic [CW-1:0] cnt  [NREQ];
  logic [DW-1:0] dout [NREQ];
  logic          ofree;
  logic          pop_any;
  src_t          sel;

  assign bus.in_ready = ~full;
  assign push         = bus.in_valid & ~full;
  assign bus.req      = req_v;

  for (genvar i = 0; i < NREQ; i++) begin : g_fifo
    req_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[i]),
      .din   (bus.in_data[i*DW +: DW]),
      .pop   (pop[i]),
      .dout  (dout[i]),
      .full  (full[i]),
      .empty (empty[i]),
      .count (cnt[i])
    );
  end

  // Pop select: lowest grant bit only; stale or stalled grants do nothing.
  always_comb begin
    ofree   = !bus.out_valid || bus.out_ready;
    sel     = low_idx(bus.gnt);
    pop_any = (bus.gnt != '0) && !empty[sel] && ofree;
    pop     = '0;
    if (pop_any) pop[sel] = 1'b1;
  end

  // Request vector to the arbiter.
  always_comb begin
    req_v = '0;
    for (int i = 0; i < NREQ; i++) begin
`ifdef ARB_REQ_LOOKAHEAD_EN
      req_v[i] = (cnt[i] > CW'(1))
               || ((cnt[i] == CW'(1)) && !pop[i])
               || push[i];
`else
      req_v[i] = (cnt[i] != '0);
`endif
    end
  end

  // Output stage: load on pop, hold while stalled, clear on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_src   <= '0;
    end else if (pop_any) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= dout[sel];
      bus.out_src   <= sel;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

  // A non-one-hot grant is tolerated (lowest bit wins) but is a bug upstream.
  a_gnt_onehot: assert property (
    @(posedge clk) disable iff (rst) $onehot0(bus.gnt)
  );

endmodule

// File: tb/tb_arb_req_queue.sv
// tb_arb_req_queue: directed stimulus, expected transactions queued,
// monitor compares every accepted output against the queue head.
module tb_arb_req_queue;
  import arb_pkg::*;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] s;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  arb_req_queue_if #(.DW(8)) bus ();

  arb_req_queue #(
    .DW    (8),
    .DEPTH (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_tx(logic [7:0] d, logic [1:0] s);
    exp_t e;
    e.d = d;
    e.s = s;
    exp_q.push_back(e);
  endtask

  task automatic set_data(int i, logic [7:0] v);
    bus.in_data[i*8 +: 8] = v;
  endtask

  // Monitor: an accept happens at the next edge when valid & ready.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_out: got %0h/%0d want none",
                 bus.out_data, bus.out_src);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_data", 32'(bus.out_data), 32'(mon_e.d));
        check("out_src", 32'(bus.out_src), 32'(mon_e.s));
      end
    end
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.gnt       = '0;
    bus.out_ready = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // reset state
    check("rst_valid", 32'(bus.out_valid), 32'h0);
    check("rst_data", 32'(bus.out_data), 32'h0);
    check("rst_src", 32'(bus.out_src), 32'h0);
    check("rst_req", 32'(bus.req), 32'h0);
    check("rst_in_ready", 32'(bus.in_ready), 32'hF);

    // single push, grant one cycle after req, output after E2
    bus.in_valid = 4'b0010;
    set_data(1, 8'hA5);
    tick();
    bus.in_valid = '0;
    check("single_req", 32'(bus.req), 32'h2);
    check("single_no_bypass", 32'(bus.out_valid), 32'h0);
    tick();
    bus.gnt = 4'b0010;
    expect_tx(8'hA5, 2'd1);
    tick();
    bus.gnt = '0;
    check("single_valid", 32'(bus.out_valid), 32'h1);
    check("single_data", 32'(bus.out_data), 32'hA5);
    check("single_src", 32'(bus.out_src), 32'h1);
    check("single_req_drop", 32'(bus.req), 32'h0);
    tick();
    check("single_clear", 32'(bus.out_valid), 32'h0);

    // fill FIFO 0, fifth push dropped, drain in order
    bus.in_valid = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      set_data(0, 8'(8'h10 + k));
      tick();
      if (k >= 3) check("full_in_ready", 32'(bus.in_ready), 32'hE);
    end
    bus.in_valid = '0;
    bus.gnt      = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      expect_tx(8'(8'h10 + k), 2'd0);
      tick();
      check("drain_valid", 32'(bus.out_valid), 32'h1);
    end
    bus.gnt = '0;
    tick();
    check("drain_clear", 32'(bus.out_valid), 32'h0);
    check("drain_req", 32'(bus.req), 32'h0);
    check("drain_in_ready", 32'(bus.in_ready), 32'hF);

    // stale grant after FIFO 2 emptied
    bus.in_valid = 4'b0100;
    set_data(2, 8'h2C);
    tick();
    bus.in_valid = '0;
    tick();
    bus.gnt = 4'b0100;
    expect_tx(8'h2C, 2'd2);
    tick();
    check("stale_first", 32'(bus.out_valid), 32'h1);
    check("stale_req", 32'(bus.req), 32'h0);
    tick();
    bus.gnt = '0;
    check("stale_ignored", 32'(bus.out_valid), 32'h0);

    // stall: grant held while output blocked
    bus.in_valid = 4'b0001;
    set_data(0, 8'h50);
    tick();
    set_data(0, 8'h51);
    tick();
    bus.in_valid  = '0;
    bus.out_ready = 1'b0;
    bus.gnt       = 4'b0001;
    expect_tx(8'h50, 2'd0);
    tick();
    check("stall_load", 32'(bus.out_data), 32'h50);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_valid", 32'(bus.out_valid), 32'h1);
      check("stall_data", 32'(bus.out_data), 32'h50);
      check("stall_req", 32'(bus.req), 32'h1);
    end
    expect_tx(8'h51, 2'd0);
    bus.out_ready = 1'b1;
    tick();
    check("stall_release_data", 32'(bus.out_data), 32'h51);
    check("stall_release_valid", 32'(bus.out_valid), 32'h1);
    bus.gnt = '0;
    tick();
    check("stall_empty_valid", 32'(bus.out_valid), 32'h0);
    check("stall_empty_req", 32'(bus.req), 32'h0);

    // all four FIFOs, two entries each, rotating grants
    bus.in_valid = 4'hF;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) set_data(i, 8'(8'h80 + (i << 4) + k));
      tick();
    end
    bus.in_valid = '0;
    check("rot_req", 32'(bus.req), 32'hF);
    tick();
    for (int n = 0; n < 8; n++) begin
      bus.gnt = vec_t'(1) << (n % 4);
      expect_tx(8'(8'h80 + ((n % 4) << 4) + (n / 4)), 2'(n % 4));
      tick();
      check("rot_valid", 32'(bus.out_valid), 32'h1);
      check("rot_src", 32'(bus.out_src), 32'(n % 4));
    end
    bus.gnt = '0;
    tick();
    check("rot_clear", 32'(bus.out_valid), 32'h0);
    check("rot_req_end", 32'(bus.req), 32'h0);

    // reset mid-burst discards FIFO contents and the held output
    bus.in_valid = 4'b0011;
    set_data(0, 8'h71);
    set_data(1, 8'h72);
    tick();
    bus.in_valid = '0;
    tick();
    bus.out_ready = 1'b0;
    bus.gnt       = 4'b0001;
    tick();
    bus.gnt = '0;
    check("mid_loaded", 32'(bus.out_valid), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_async_valid", 32'(bus.out_valid), 32'h0);
    check("mid_async_data", 32'(bus.out_data), 32'h0);
    check("mid_async_req", 32'(bus.req), 32'h0);
    check("mid_async_in_ready", 32'(bus.in_ready), 32'hF);
    tick();
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    check("post_rst_valid", 32'(bus.out_valid), 32'h0);
    check("post_rst_req", 32'(bus.req), 32'h0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
